// File: rtl/obstacle_field.sv
// obstacle_field: falling-obstacle game engine.
//   A field of 16 green rows scrolls downward (g1 = top) every SHIFT_PERIOD
//   clocks. Every other shift inserts an obstacle row with a 3-bit gap at a
//   position picked by an LFSR; the rows in between are empty. The player is
//   a one-hot marker displayed on the same row as g4, and the game ends when
//   the marker overlaps a set bit of g4.
// Ports:
//   clk        system clock, rising edge
//   RST_n      asynchronous active-low reset
//   start      start/restart request (level)
//   left/right move the player toward bit 15 / bit 0 on a rising edge
//   g1..g16    registered green rows, top to bottom
//   row16      registered one-hot player marker
//   collision  high while the game is over
//   score      completed shifts since start, saturating at 255
//
// state  | meaning
// S_IDLE | waiting for start; field cleared, score from last game shown
// S_RUN  | field scrolling, player moves accepted, overlap checked
// S_OVER | everything frozen, collision flag held
module obstacle_field #(
  parameter int unsigned SHIFT_PERIOD = 25_000_000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        RST_n,
  input  logic        start,
  input  logic        left,
  input  logic        right,
  output logic [15:0] g1,
  output logic [15:0] g2,
  output logic [15:0] g3,
  output logic [15:0] g4,
  output logic [15:0] g5,
  output logic [15:0] g6,
  output logic [15:0] g7,
  output logic [15:0] g8,
  output logic [15:0] g9,
  output logic [15:0] g10,
  output logic [15:0] g11,
  output logic [15:0] g12,
  output logic [15:0] g13,
  output logic [15:0] g14,
  output logic [15:0] g15,
  output logic [15:0] g16,
  output logic [15:0] row16,
  output logic        collision,
  output logic [7:0]  score
);

  localparam int unsigned TW = (SHIFT_PERIOD > 1) ? $clog2(SHIFT_PERIOD) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SHIFT_PERIOD - 1);
  localparam logic [15:0] PLAYER_HOME = 16'h0080;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_e;

  state_e        state_q, state_d;
  logic [15:0]   rows_q [16];
  logic [15:0]   rows_d [16];
  logic [15:0]   row16_q, row16_d;
  logic          coll_q, coll_d;
  logic [7:0]    score_q, score_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          par_q, par_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          left_q, right_q;

  logic        left_rise, right_rise;
  logic        hit;
  logic        shift_evt;
  logic [3:0]  gap_pos;
  logic [15:0] new_row;
  logic        lfsr_fb;

  assign left_rise  = left & ~left_q;
  assign right_rise = right & ~right_q;
  assign hit        = |(row16_q & rows_q[3]);
  assign shift_evt  = (tick_q == TICK_LAST);
  // Gap occupies bits gap_pos..gap_pos+2, so it must stop at 13 to stay on the field.
  assign gap_pos    = (lfsr_q[3:0] > 4'd13) ? 4'd13 : lfsr_q[3:0];
  assign new_row    = par_q ? ~(16'h0007 << gap_pos) : 16'h0000;
  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    row16_d = row16_q;
    coll_d  = coll_q;
    score_d = score_q;
    tick_d  = tick_q;
    par_d   = par_q;
    lfsr_d  = lfsr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          rows_d  = '{default: '0};
          score_d = '0;
          tick_d  = '0;
          par_d   = 1'b0;
        end
      end
      S_RUN: begin
        // A hit freezes the field on the spot; the shift/move of that cycle is dropped.
        if (hit) begin
          state_d = S_OVER;
          coll_d  = 1'b1;
        end else begin
          if (shift_evt) begin
            tick_d    = '0;
            rows_d[0] = new_row;
            for (int i = 1; i < 16; i++) begin
              rows_d[i] = rows_q[i-1];
            end
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
            par_d  = ~par_q;
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
          end else begin
            tick_d = tick_q + TW'(1);
          end
          if (left_rise && !right_rise && !row16_q[15]) begin
            row16_d = row16_q << 1;
          end else if (right_rise && !left_rise && !row16_q[0]) begin
            row16_d = row16_q >> 1;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          state_d = S_IDLE;
          coll_d  = 1'b0;
          rows_d  = '{default: '0};
          row16_d = PLAYER_HOME;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      rows_q  <= '{default: '0};
      row16_q <= PLAYER_HOME;
      coll_q  <= 1'b0;
      score_q <= '0;
      tick_q  <= '0;
      par_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      row16_q <= row16_d;
      coll_q  <= coll_d;
      score_q <= score_d;
      tick_q  <= tick_d;
      par_q   <= par_d;
      lfsr_q  <= lfsr_d;
      left_q  <= left;
      right_q <= right;
    end
  end

  assign g1        = rows_q[0];
  assign g2        = rows_q[1];
  assign g3        = rows_q[2];
  assign g4        = rows_q[3];
  assign g5        = rows_q[4];
  assign g6        = rows_q[5];
  assign g7        = rows_q[6];
  assign g8        = rows_q[7];
  assign g9        = rows_q[8];
  assign g10       = rows_q[9];
  assign g11       = rows_q[10];
  assign g12       = rows_q[11];
  assign g13       = rows_q[12];
  assign g14       = rows_q[13];
  assign g15       = rows_q[14];
  assign g16       = rows_q[15];
  assign row16     = row16_q;
  assign collision = coll_q;
  assign score     = score_q;

endmodule
